// File: rtl/counter_pkg.sv
// counter_pkg: shared types and defaults for programmable_counter.
//   dir_e          : counting direction carried on the Sel input
//   DEFAULT_WIDTH  : default counter width in bits
//   DEFAULT_MOD    : default counting modulus
package counter_pkg;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam int DEFAULT_WIDTH = 4;
  localparam int DEFAULT_MOD   = 16;

endpackage

// File: rtl/counter_next_value.sv
// counter_next_value: purely combinational next-count calculation.
// Given the current count, the direction and the saturate request, it
// produces the value the counter takes on an enabled edge and whether that
// step is a wrap.
//   cur      in   WIDTH  current registered count
//   dir      in   dir_e  counting direction
//   sat      in   1      hold at the terminal value instead of wrapping
//   nxt      out  WIDTH  count after one enabled step
//   wrap     out  1      this step wraps around the modulus
//   at_term  out  1      cur is the terminal value for dir
module counter_next_value
  import counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int MOD   = DEFAULT_MOD
) (
  input  logic [WIDTH-1:0] cur,
  input  dir_e             dir,
  input  logic             sat,
  output logic [WIDTH-1:0] nxt,
  output logic             wrap,
  output logic             at_term
);

  // Largest legal count, held one bit wider so it compares directly with
  // the widened arithmetic results below.
  localparam logic [WIDTH:0] TOP = (WIDTH+1)'(MOD - 1);

  logic [WIDTH:0] cur_ext;
  logic [WIDTH:0] inc;
  logic [WIDTH:0] dec;

  assign cur_ext = {1'b0, cur};
  assign inc     = cur_ext + 1'b1;
  assign dec     = cur_ext - 1'b1;

  always_comb begin
    nxt     = cur;
    wrap    = 1'b0;
    at_term = 1'b0;
    if (cur_ext > TOP) begin
      // Out-of-range count (corruption): snap back to the start value for
      // the current direction without signalling a wrap.
      nxt = (dir == DIR_UP) ? '0 : TOP[WIDTH-1:0];
    end else if (dir == DIR_UP) begin
      // Increment overshoots the top exactly when cur == MOD-1.
      at_term = (inc > TOP);
      if (!at_term) begin
        nxt = inc[WIDTH-1:0];
      end else if (!sat) begin
        nxt  = '0;
        wrap = 1'b1;
      end
    end else begin
      // The extra bit of the widened decrement is the borrow out of zero.
      at_term = dec[WIDTH];
      if (!at_term) begin
        nxt = dec[WIDTH-1:0];
      end else if (!sat) begin
        nxt  = TOP[WIDTH-1:0];
        wrap = 1'b1;
      end
    end
  end

endmodule

// File: rtl/programmable_counter.sv
// programmable_counter: modulo-MOD up/down counter with synchronous load.
// Edge priority is reset > load > en. Saida and wrap are registered; tc is
// combinational.
// Optional feature: define PROGRAMMABLE_COUNTER_SAT_EN to add the sat input,
// which makes the counter stick at its terminal value instead of wrapping.
//   clk       in   1      rising-edge clock
//   reset     in   1      synchronous active-high reset
//   en        in   1      count enable
//   Sel       in   1      direction: 0 = up, 1 = down
//   load      in   1      synchronous parallel load strobe
//   load_val  in   WIDTH  load value (clamped to MOD-1)
//   sat       in   1      saturate instead of wrap (macro builds only)
//   Saida     out  WIDTH  registered count
//   tc        out  1      en=1 and Saida at terminal value for Sel
//   wrap      out  1      one-cycle pulse the cycle after a wrap
module programmable_counter
  import counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int MOD   = DEFAULT_MOD
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             Sel,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
`ifdef PROGRAMMABLE_COUNTER_SAT_EN
  input  logic             sat,
`endif
  output logic [WIDTH-1:0] Saida,
  output logic             tc,
  output logic             wrap
);

  // Reject moduli that cannot be represented or that make no counter.
  if (MOD < 2 || MOD > (2 ** WIDTH)) begin : g_bad_mod
    $error("programmable_counter: MOD must satisfy 2 <= MOD <= 2**WIDTH");
  end

  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MOD);
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 1);

  dir_e             dir;
  logic             sat_i;
  logic [WIDTH-1:0] nxt;
  logic             nxt_wrap;
  logic             at_term;
  logic [WIDTH-1:0] load_clamped;

  assign dir = dir_e'(Sel);

`ifdef PROGRAMMABLE_COUNTER_SAT_EN
  assign sat_i = sat;
`else
  assign sat_i = 1'b0;
`endif

  counter_next_value #(
    .WIDTH (WIDTH),
    .MOD   (MOD)
  ) u_next (
    .cur     (Saida),
    .dir     (dir),
    .sat     (sat_i),
    .nxt     (nxt),
    .wrap    (nxt_wrap),
    .at_term (at_term)
  );

  assign load_clamped = ({1'b0, load_val} < MOD_EXT) ? load_val : MAX_VAL;

  assign tc = en & at_term;

  always_ff @(posedge clk) begin
    if (reset) begin
      Saida <= (dir == DIR_DOWN) ? MAX_VAL : '0;
      wrap  <= 1'b0;
    end else if (load) begin
      Saida <= load_clamped;
      wrap  <= 1'b0;
    end else if (en) begin
      Saida <= nxt;
      wrap  <= nxt_wrap;
    end else begin
      wrap  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_programmable_counter.sv
// tb_programmable_counter: directed and random checks of programmable_counter
// with WIDTH=4, MOD=10 against a modular-arithmetic reference model.
module tb_programmable_counter;

  localparam int WIDTH = 4;
  localparam int MOD   = 10;

  // ---------------- clock / reset block ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic             en;
  logic             sel;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             sat;
  logic [WIDTH-1:0] saida;
  logic             tc;
  logic             wrap;

  programmable_counter #(
    .WIDTH (WIDTH),
    .MOD   (MOD)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .Sel      (sel),
    .load     (load),
    .load_val (load_val),
`ifdef PROGRAMMABLE_COUNTER_SAT_EN
    .sat      (sat),
`endif
    .Saida    (saida),
    .tc       (tc),
    .wrap     (wrap)
  );

  // ---------------- scoreboard / reference model ----------------
  int n_assert = 0;
  int n_fail   = 0;
  int m_cnt    = 0;
  int m_wrap   = 0;
  bit m_valid  = 1'b0;
  int wrap_seen = 0;
  logic [WIDTH-1:0] exp_q[$];

  function automatic bit sat_active();
`ifdef PROGRAMMABLE_COUNTER_SAT_EN
    return sat;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock edge of the specified behaviour, written as modular arithmetic.
  task automatic model_edge();
    int step;
    int nv;
    bit wrapped;
    if (reset) begin
      m_cnt  = sel ? MOD - 1 : 0;
      m_wrap = 0;
    end else if (load) begin
      m_cnt  = (int'(load_val) < MOD) ? int'(load_val) : MOD - 1;
      m_wrap = 0;
    end else if (en) begin
      step    = sel ? MOD - 1 : 1;
      nv      = (m_cnt + step) % MOD;
      wrapped = sel ? (nv > m_cnt) : (nv < m_cnt);
      if (wrapped && sat_active()) begin
        m_wrap = 0;
      end else begin
        m_cnt  = nv;
        m_wrap = wrapped ? 1 : 0;
      end
    end else begin
      m_wrap = 0;
    end
    m_valid = 1'b1;
  endtask

  // ---------------- driver tasks ----------------
  // Inputs are changed just after a rising edge; tc is checked at the
  // falling edge, registered outputs 1 time unit after the rising edge.
  task automatic cycle();
    bit exp_tc;
    @(negedge clk);
    if (m_valid) begin
      exp_tc = en && (m_cnt == (sel ? 0 : MOD - 1));
      check("tc", {31'b0, tc}, {31'b0, exp_tc});
    end
    @(posedge clk);
    model_edge();
    #1;
    check("saida", {28'b0, saida}, m_cnt);
    check("wrap", {31'b0, wrap}, m_wrap);
    if (wrap === 1'b1) wrap_seen++;
  endtask

  task automatic drive(input logic r, input logic e, input logic s,
                       input logic l, input logic [WIDTH-1:0] lv);
    reset = r; en = e; sel = s; load = l; load_val = lv;
  endtask

  task automatic expect_seq(input string tag);
    logic [WIDTH-1:0] v;
    while (exp_q.size() > 0) begin
      v = exp_q.pop_front();
      cycle();
      check(tag, {28'b0, saida}, {28'b0, v});
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
    sat = 1'b0;

    // Reset state, counting up
    cycle();
    check("reset_up_saida", {28'b0, saida}, 32'd0);

    // Up count 12 cycles: 1..9,0,1,2 with one wrap pulse
    drive(1'b0, 1'b1, 1'b0, 1'b0, '0);
    wrap_seen = 0;
    for (int i = 1; i <= 12; i++) exp_q.push_back(WIDTH'(i % MOD));
    expect_seq("up_seq");
    check("up_wrap_once", wrap_seen, 32'd1);

    // Reset counting down, then 11 down steps: 8..0,9,8
    drive(1'b1, 1'b1, 1'b1, 1'b0, '0);
    cycle();
    check("reset_down_saida", {28'b0, saida}, 32'd9);
    drive(1'b0, 1'b1, 1'b1, 1'b0, '0);
    wrap_seen = 0;
    for (int i = 1; i <= 11; i++) exp_q.push_back(WIDTH'((MOD - 1) - (i % MOD)));
    expect_seq("down_seq");
    check("down_wrap_once", wrap_seen, 32'd1);

    // Load clamp, then load overriding enable
    drive(1'b0, 1'b0, 1'b0, 1'b1, 4'd13);
    cycle();
    check("load_clamp", {28'b0, saida}, 32'd9);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 4'd5);
    cycle();
    check("load_over_en", {28'b0, saida}, 32'd5);

    // Direction change has no latency: 4 -> 5 -> 4 -> 3
    drive(1'b0, 1'b0, 1'b0, 1'b1, 4'd4);
    cycle();
    drive(1'b0, 1'b1, 1'b0, 1'b0, '0);
    cycle();
    check("sel_up", {28'b0, saida}, 32'd5);
    sel = 1'b1;
    exp_q.push_back(4'd4);
    exp_q.push_back(4'd3);
    expect_seq("sel_down");

    // Reset mid-count overriding load, both directions
    drive(1'b0, 1'b0, 1'b0, 1'b1, 4'd7);
    cycle();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 4'd2);
    cycle();
    check("reset_over_load_up", {28'b0, saida}, 32'd0);
    check("reset_wrap_up", {31'b0, wrap}, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 4'd7);
    cycle();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 4'd2);
    cycle();
    check("reset_over_load_down", {28'b0, saida}, 32'd9);

    // Up from 8 across the terminal value (sat requested)
    drive(1'b0, 1'b0, 1'b0, 1'b1, 4'd8);
    cycle();
    drive(1'b0, 1'b1, 1'b0, 1'b0, '0);
    sat = 1'b1;
`ifdef PROGRAMMABLE_COUNTER_SAT_EN
    exp_q.push_back(4'd9); exp_q.push_back(4'd9); exp_q.push_back(4'd9);
`else
    exp_q.push_back(4'd9); exp_q.push_back(4'd0); exp_q.push_back(4'd1);
`endif
    expect_seq("sat_seq");
    sat = 1'b0;

    // Hold with en=0
    drive(1'b0, 1'b0, 1'b1, 1'b0, '0);
    cycle();
    cycle();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
            WIDTH'($urandom_range(0, 15)));
      sat = 1'($urandom_range(0, 3) == 0);
      cycle();
    end

    // ---------------- final report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
